des_subkey_sequencer: RTL and testbench

Sequential DES key-schedule engine. It accepts a 64-bit DES key and emits the 16 round subkeys (48 bits each), one per valid/ready handshake. Order is forward (K1..K16) for encryption or reverse (K16..K1) for decryption. It contains its own PC-1, C/D rotation registers and PC-2 selection, and feeds the round pipeline or a subkey buffer ahead of it.

---
 rtl/des_subkey_sequencer_if.sv | 28 ++
 rtl/des_subkey_sequencer.sv | 152 +++++++++++++++
 tb/tb_des_subkey_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_subkey_sequencer_if.sv
// Subkey request/stream bundle between the key-schedule engine and its consumer.
//
// Handshake: the engine raises subkey_valid while it holds a round key on
// subkey/round/last. A beat transfers on every rising edge where
// subkey_valid && subkey_ready. While valid is high and ready is low, the
// engine keeps subkey, round and last stable. The consumer may raise ready
// at any time. start/decrypt/key are only looked at while busy is low.
interface des_subkey_sequencer_if;
  logic        start;
  logic        decrypt;
  logic [0:63] key;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [0:47] subkey;
  logic [3:0]  round;
  logic        last;

  modport slave (
    input  start, decrypt, key, subkey_ready,
    output busy, subkey_valid, subkey, round, last
  );

  modport master (
    output start, decrypt, key, subkey_ready,
    input  busy, subkey_valid, subkey, round, last
  );
endinterface

// File: rtl/des_subkey_sequencer.sv
// DES key-schedule engine: PC-1 on start, per-round C/D rotation, PC-2 output.
// Emits K1..K16 (encrypt) or K16..K1 (decrypt), one subkey per handshake.
// Bit vectors use DES numbering: index 0 is DES bit 1.
module des_subkey_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  des_subkey_sequencer_if.slave  bus,
  output logic                   dbg_run
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:27] rot_l(input logic [0:27] v, input logic two);
    rot_l = two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

  function automatic logic [0:27] rot_r(input logic [0:27] v, input logic two);
    rot_r = two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction

  state_e      state_q, state_d;
  logic [0:27] c_q, c_d;
  logic [0:27] d_q, d_d;
  logic [3:0]  n_q, n_d;
  logic        dec_q, dec_d;

  logic [0:55] pc1_cd;
  logic [0:55] cd;
  logic [0:47] sk;
  logic [4:0]  s_idx;
  logic        shift_two;
  logic        run;
  logic        xfer;
  logic        unused_parity;

  // Parity bits of the key never enter the schedule.
  assign unused_parity = ^{bus.key[7], bus.key[15], bus.key[23], bus.key[31],
                           bus.key[39], bus.key[47], bus.key[55], bus.key[63]};

  // PC-1 of the presented key.
  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 56; i++) pc1_cd[6'(i)] = bus.key[6'(PC1[i] - 1)];
  end

  // PC-2 of the current C||D, purely from registers.
  always_comb begin
    cd = {c_q, d_q};
    sk = '0;
    for (int i = 0; i < 48; i++) sk[6'(i)] = cd[6'(PC2[i] - 1)];
  end

  // Shift-table position for the next rotation and whether it is a 2-bit shift.
  always_comb begin
    s_idx     = dec_q ? (5'd16 - {1'b0, n_q}) : ({1'b0, n_q} + 5'd2);
    shift_two = !((s_idx == 5'd1) || (s_idx == 5'd2) ||
                  (s_idx == 5'd9) || (s_idx == 5'd16));
  end

  assign run  = (state_q == S_RUN);
  assign xfer = run && bus.subkey_ready;

  // Next-state logic: load on start, rotate on each accepted subkey.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    n_d     = n_q;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dec_d   = bus.decrypt;
          n_d     = 4'd0;
          state_d = S_RUN;
          // Decrypt starts from C16D16, which equals C0D0.
          if (bus.decrypt) begin
            c_d = pc1_cd[0:27];
            d_d = pc1_cd[28:55];
          end else begin
            c_d = rot_l(pc1_cd[0:27], 1'b0);
            d_d = rot_l(pc1_cd[28:55], 1'b0);
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (n_q == 4'd15) begin
            state_d = S_IDLE;
          end else begin
            n_d = n_q + 4'd1;
            if (dec_q) begin
              c_d = rot_r(c_q, shift_two);
              d_d = rot_r(d_q, shift_two);
            end else begin
              c_d = rot_l(c_q, shift_two);
              d_d = rot_l(d_q, shift_two);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      n_q     <= n_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.busy         = run;
  assign bus.subkey_valid = run;
  assign bus.subkey       = sk;
  assign bus.round        = dec_q ? (4'd15 - n_q) : n_q;
  assign bus.last         = run && (n_q == 4'd15);
  assign dbg_run          = run;

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// Bench for des_subkey_sequencer: directed DES vectors, a reference key
// schedule for random keys, stalls, ignored starts and mid-run reset.
module tb_des_subkey_sequencer;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123456789ABCDEF0;

  // Published K1..K16 for KEY_A.
  logic [47:0] ref_ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic clk = 1'b0;
  logic rst;
  logic dbg_run;
  des_subkey_sequencer_if sif ();

  des_subkey_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (sif.slave),
    .dbg_run (dbg_run)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q [$];
  logic [47:0] model_ks [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference key schedule: PC-1, cumulative left rotations, PC-2.
  task automatic model_schedule(input logic [63:0] k);
    logic [27:0] c;
    logic [27:0] d;
    int pos;
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = k[6'(64 - PC1_T[i])];
      d[5'(27 - i)] = k[6'(64 - PC1_T[i + 28])];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      for (int i = 0; i < 48; i++) begin
        pos = PC2_T[i];
        model_ks[r][6'(47 - i)] = (pos <= 28) ? c[5'(28 - pos)] : d[5'(56 - pos)];
      end
    end
  endtask

  // Queue the expected emission order for one schedule.
  task automatic push_expected(input logic dec, input bit use_ref);
    for (int i = 0; i < 16; i++) begin
      if (use_ref) exp_q.push_back(dec ? ref_ks[15 - i] : ref_ks[i]);
      else         exp_q.push_back(dec ? model_ks[15 - i] : model_ks[i]);
    end
  endtask

  // Driver + scoreboard for one schedule; start is raised in the current cycle.
  task automatic drive_schedule(input logic [63:0] k, input logic dec,
                                input bit rand_ready, input bit inject, input string tag);
    int xfers;
    bit done;
    bit stalled;
    logic [47:0] exp_sk;
    logic [47:0] hold_sk;
    logic [3:0]  hold_round;
    logic        hold_last;
    logic [3:0]  exp_round;
    xfers = 0;
    done = 0;
    stalled = 0;
    hold_sk = '0;
    hold_round = '0;
    hold_last = 1'b0;
    checks++;
    if (sif.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before_start: busy=%b required 0", tag, sif.busy);
    end
    sif.start = 1'b1;
    sif.key = k;
    sif.decrypt = dec;
    sif.subkey_ready = 1'b0;
    step();
    sif.start = 1'b0;
    sif.key = {$urandom, $urandom};
    sif.decrypt = ~dec;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      checks++;
      if (sif.subkey_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s valid: subkey_valid=%b required 1 at beat %0d", tag, sif.subkey_valid, xfers);
        break;
      end
      if (stalled) begin
        checks++;
        if (sif.subkey !== hold_sk || sif.round !== hold_round || sif.last !== hold_last) begin
          errors++;
          $display("FAIL %s stall_hold: subkey=%h round=%0d last=%b required %h %0d %b",
                   tag, sif.subkey, sif.round, sif.last, hold_sk, hold_round, hold_last);
        end
      end
      sif.subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject) begin
        sif.start = 1'b1;
        sif.key = {$urandom, $urandom};
        sif.decrypt = 1'($urandom_range(0, 1));
      end
      if (sif.subkey_ready) begin
        exp_sk = (exp_q.size() > 0) ? exp_q.pop_front() : 48'h0;
        exp_round = dec ? 4'(15 - xfers) : 4'(xfers);
        checks++;
        if (sif.subkey !== exp_sk) begin
          errors++;
          $display("FAIL %s subkey[%0d]: got %h required %h", tag, xfers, sif.subkey, exp_sk);
        end
        checks++;
        if (sif.round !== exp_round) begin
          errors++;
          $display("FAIL %s round[%0d]: got %0d required %0d", tag, xfers, sif.round, exp_round);
        end
        checks++;
        if (sif.last !== (xfers == 15)) begin
          errors++;
          $display("FAIL %s last[%0d]: got %b required %b", tag, xfers, sif.last, (xfers == 15));
        end
        xfers++;
        if (xfers == 16) done = 1;
        stalled = 0;
      end else begin
        stalled = 1;
        hold_sk = sif.subkey;
        hold_round = sif.round;
        hold_last = sif.last;
      end
      step();
      sif.start = 1'b0;
      sif.subkey_ready = 1'b0;
    end
    checks++;
    if (xfers != 16) begin
      errors++;
      $display("FAIL %s transfer_count: got %0d required 16", tag, xfers);
    end
    checks++;
    if (sif.busy !== 1'b0 || sif.subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_idle: busy=%b valid=%b required 0 0", tag, sif.busy, sif.subkey_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", sif.busy); end
    checks++;
    if (sif.subkey_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", sif.subkey_valid); end
    checks++;
    if (sif.subkey !== 48'h0) begin errors++; $display("FAIL reset_subkey: got %h required 0", sif.subkey); end
    checks++;
    if (sif.round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d required 0", sif.round); end
    checks++;
    if (sif.last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", sif.last); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_encrypt();
    push_expected(1'b0, 1);
    drive_schedule(KEY_A, 1'b0, 0, 0, "encrypt");
  endtask

  task automatic test_decrypt();
    push_expected(1'b1, 1);
    drive_schedule(KEY_A, 1'b1, 0, 0, "decrypt");
  endtask

  task automatic test_parity();
    push_expected(1'b0, 1);
    drive_schedule(KEY_P, 1'b0, 1, 0, "parity_enc");
    push_expected(1'b1, 1);
    drive_schedule(KEY_P, 1'b1, 1, 0, "parity_dec");
  endtask

  task automatic test_random();
    logic [63:0] k;
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom};
      model_schedule(k);
      push_expected(1'(i), 0);
      drive_schedule(k, 1'(i), 1, 0, "random");
    end
  endtask

  // Starts during RUN and on the final transfer are ignored; the one in the
  // very next idle cycle is taken (back-to-back).
  task automatic test_start_ignored();
    logic [63:0] k2;
    k2 = 64'h0E329232EA6D0D73;
    push_expected(1'b0, 1);
    drive_schedule(KEY_A, 1'b0, 0, 1, "start_ignored");
    model_schedule(k2);
    push_expected(1'b1, 0);
    drive_schedule(k2, 1'b1, 0, 0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    sif.start = 1'b1;
    sif.key = KEY_A;
    sif.decrypt = 1'b0;
    step();
    sif.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.subkey_ready = 1'b1;
      checks++;
      if (sif.subkey !== ref_ks[i]) begin
        errors++;
        $display("FAIL reset_mid_subkey[%0d]: got %h required %h", i, sif.subkey, ref_ks[i]);
      end
      step();
    end
    sif.subkey_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (sif.busy !== 1'b0 || sif.subkey_valid !== 1'b0 || sif.subkey !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid_abort: busy=%b valid=%b subkey=%h required 0 0 0",
               sif.busy, sif.subkey_valid, sif.subkey);
    end
    push_expected(1'b0, 1);
    drive_schedule(KEY_A, 1'b0, 0, 0, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    sif.start = 1'b0;
    sif.decrypt = 1'b0;
    sif.key = '0;
    sif.subkey_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_start_ignored();
    test_reset_mid();
    test_parity();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
